// File: rtl/clk_lock_supervisor.sv
// clk_lock_supervisor: drives the MMCM reset, waits for LOCKED, retries on
// lock timeout, and releases the system reset once lock has been stable for
// a settle window. Counts lock losses (in RUN) and lock timeouts.
// Optional macro LOCK_DEBOUNCE_EN: in RUN, loss is declared only after
// locked_s has been low for 4 consecutive cycles.
module clk_lock_supervisor #(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 40000,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             locked_in,
  input  logic             clear_cnt,
  output logic             mmcm_rst,
  output logic             sys_reset_n,
  output logic             clk_good,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [1:0]       state_dbg
);

  localparam int unsigned MAX_A = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int unsigned MAX_T = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned TW    = $clog2(MAX_T + 1);

  typedef logic [TW-1:0] timer_t;
  localparam timer_t RST_LAST    = timer_t'(RST_PULSE - 1);
  localparam timer_t TIMEOUT_LAST = timer_t'(LOCK_TIMEOUT - 1);
  localparam timer_t SETTLE_LAST = timer_t'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t state, state_nxt;
  timer_t timer;
  logic   sync1, locked_s;
  logic   loss_det, retry_inc, loss_inc;

  // Two-flop synchronizer for the asynchronous LOCKED input
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
    end
  end

`ifdef LOCK_DEBOUNCE_EN
  logic [1:0] deb_cnt;

  // Count consecutive low lock samples while in RUN
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)
      deb_cnt <= '0;
    else if (state != ST_RUN || locked_s)
      deb_cnt <= '0;
    else if (deb_cnt != 2'd3)
      deb_cnt <= deb_cnt + 2'd1;
  end

  // Loss is the fourth consecutive low sample
  always_comb loss_det = !locked_s && (deb_cnt == 2'd3);
`else
  // Any single low sample in RUN is a loss
  always_comb loss_det = !locked_s;
`endif

  // Next-state decode and counter increment requests
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      ST_RESET: begin
        if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_SETTLE;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = ST_RESET;
          retry_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) state_nxt = ST_RESET;
        else if (timer == SETTLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (loss_det) begin
          state_nxt = ST_RESET;
          loss_inc  = 1'b1;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // State, shared timer (cleared on entry) and outputs decoded from next state
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      timer       <= '0;
      mmcm_rst    <= 1'b1;
      sys_reset_n <= 1'b0;
      clk_good    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (state != ST_RUN)
        timer <= timer + timer_t'(1);
      mmcm_rst    <= (state_nxt == ST_RESET);
      sys_reset_n <= (state_nxt == ST_RUN);
      clk_good    <= (state_nxt == ST_RUN);
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else if (clear_cnt) begin
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (retry_inc && retry_cnt != '1)
        retry_cnt <= retry_cnt + CNT_ONE;
      if (loss_inc && lock_loss_cnt != '1)
        lock_loss_cnt <= lock_loss_cnt + CNT_ONE;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Scoreboard bench for clk_lock_supervisor (RST_PULSE=4, LOCK_TIMEOUT=50,
// SETTLE_CYCLES=10, CNT_W=2). Expected state snapshots are queued with the
// edge count after which they must hold; the monitor compares them.
module tb_clk_lock_supervisor;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked_in = 1'b0;
  logic       clear_cnt = 1'b0;
  logic       mmcm_rst, sys_reset_n, clk_good;
  logic [1:0] lock_loss_cnt, retry_cnt, state_dbg;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    at;
    bit    async;
    int    st;
    int    rc;
    int    lc;
    string nm;
  } exp_t;

  exp_t sb[$];

  clk_lock_supervisor #(
    .RST_PULSE(4),
    .LOCK_TIMEOUT(50),
    .SETTLE_CYCLES(10),
    .CNT_W(2)
  ) dut (
    .Clk(Clk),
    .rst_n(rst_n),
    .locked_in(locked_in),
    .clear_cnt(clear_cnt),
    .mmcm_rst(mmcm_rst),
    .sys_reset_n(sys_reset_n),
    .clk_good(clk_good),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, cyc);
    end
  endtask

  // rc/lc of -1 mean "not checked"; output levels follow from the state
  task automatic push(input int at, input string nm, input int st, input int rc, input int lc);
    exp_t e;
    e.at = at; e.async = 1'b0; e.st = st; e.rc = rc; e.lc = lc; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic push_async(input string nm, input int st, input int rc, input int lc);
    exp_t e;
    e.at = 0; e.async = 1'b1; e.st = st; e.rc = rc; e.lc = lc; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc != n) @(negedge Clk);
  endtask

  // Monitor: compare queued expectations against the DUT outputs
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk or negedge rst_n);
      #1;
      while (sb.size() > 0 && (sb[0].async ? !rst_n : (sb[0].at <= cyc))) begin
        e = sb.pop_front();
        check({e.nm, ".state"}, int'(state_dbg), e.st);
        check({e.nm, ".mmcm_rst"}, int'(mmcm_rst), (e.st == 0) ? 1 : 0);
        check({e.nm, ".sys_reset_n"}, int'(sys_reset_n), (e.st == 3) ? 1 : 0);
        check({e.nm, ".clk_good"}, int'(clk_good), (e.st == 3) ? 1 : 0);
        if (e.rc >= 0) check({e.nm, ".retry_cnt"}, int'(retry_cnt), e.rc);
        if (e.lc >= 0) check({e.nm, ".lock_loss_cnt"}, int'(lock_loss_cnt), e.lc);
      end
    end
  end

  initial begin : stim
    int L;
    // Power-on reset and clean start: release at edge 3, lock before edge 24
    push(1, "por", 0, 0, 0);
    push(6, "start_rst_last", 0, -1, -1);
    push(7, "start_wl", 1, -1, -1);
    push(25, "acq_wl", 1, -1, -1);
    push(26, "acq_settle", 2, -1, -1);
    push(35, "acq_settle_end", 2, -1, -1);
    push(36, "acq_run", 3, 0, 0);
    wait_cyc(3);  rst_n = 1'b1;
    wait_cyc(23); locked_in = 1'b1;

    // Loss in RUN
`ifdef LOCK_DEBOUNCE_EN
    push(43, "blip_run_a", 3, -1, 0);
    push(46, "blip_run_b", 3, -1, 0);
    push(55, "loss_pre", 3, 0, 0);
    push(56, "loss_rst", 0, 0, 1);
    push(60, "loss_wl", 1, 0, 1);
    push(61, "loss_settle", 2, 0, 1);
    push(71, "loss_run", 3, 0, 1);
    wait_cyc(40); locked_in = 1'b0;
    wait_cyc(41); locked_in = 1'b1;
    wait_cyc(50); locked_in = 1'b0;
    wait_cyc(55); locked_in = 1'b1;
`else
    push(42, "loss_pre", 3, 0, 0);
    push(43, "loss_rst", 0, 0, 1);
    push(47, "loss_wl", 1, 0, 1);
    push(48, "loss_settle", 2, 0, 1);
    push(58, "loss_run", 3, 0, 1);
    wait_cyc(40); locked_in = 1'b0;
    wait_cyc(41); locked_in = 1'b1;
`endif

    // Asynchronous reset mid-RUN, checked between clock edges
    wait_cyc(75);
    #3;
    push_async("arst", 0, 0, 0);
    locked_in = 1'b0;
    rst_n = 1'b0;

    // Restart with two timeouts, then a glitch during SETTLE
    wait_cyc(77); rst_n = 1'b1;
    push(80, "to_rst_last", 0, 0, 0);
    push(81, "to_wl1", 1, 0, 0);
    push(130, "to_wl1_end", 1, 0, 0);
    push(131, "to_rst2", 0, 1, 0);
    push(134, "to_rst2_last", 0, 1, 0);
    push(135, "to_wl2", 1, 1, 0);
    push(184, "to_wl2_end", 1, 1, 0);
    push(185, "to_rst3", 0, 2, 0);
    push(189, "to_wl3", 1, 2, 0);
    push(209, "to_wl3_lock", 1, 2, 0);
    push(210, "to_settle", 2, 2, 0);
    push(214, "gl_settle", 2, 2, 0);
    push(215, "gl_rst", 0, 2, 0);
    push(218, "gl_rst_last", 0, 2, 0);
    push(219, "gl_wl", 1, 2, 0);
    push(220, "gl_settle2", 2, 2, 0);
    push(229, "gl_settle2_end", 2, 2, 0);
    push(230, "gl_run", 3, 2, 0);
    wait_cyc(207); locked_in = 1'b1;
    wait_cyc(212); locked_in = 1'b0;
    wait_cyc(215); locked_in = 1'b1;

    // Permanent loss, repeated timeouts, saturation and clear on a timeout edge
`ifdef LOCK_DEBOUNCE_EN
    L = 241;
`else
    L = 238;
`endif
    push(L - 1, "sat_run", 3, 2, 0);
    push(L, "sat_loss", 0, 2, 1);
    push(L + 4, "sat_wl", 1, 2, 1);
    push(L + 54, "sat_to1", 0, 3, 1);
    push(L + 270, "sat_to5", 0, 3, 1);
    push(L + 323, "sat_pre_clr", 1, 3, 1);
    push(L + 324, "sat_clr", 0, 0, 0);
    wait_cyc(235);   locked_in = 1'b0;
    wait_cyc(L + 323); clear_cnt = 1'b1;
    wait_cyc(L + 324); clear_cnt = 1'b0;
    wait_cyc(L + 330);

    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_lock_supervisor.md
# clk_lock_supervisor

- Supervises the clock manager's MMCM from a free-running clock.
- Drives the MMCM reset request and watches its LOCKED status, retrying the MMCM when lock is not reached in time.
- Releases the system reset only after lock has been stable for a settle window.
- Counts lock-loss and retry events for slow control; sits between the board reset/oscillator and every downstream clock-domain reset.

## Interface
Parameters:
- RST_PULSE, 16: cycles `mmcm_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 40000: cycles to wait for lock before re-resetting the MMCM (1 ms at 40 MHz; ≥1).
- SETTLE_CYCLES, 4096: cycles lock must stay high before system reset release (≥1).
- CNT_W, 8: width of the event counters.

Ports:
- Clk  in  1  free-running 40 MHz oscillator clock (not an MMCM output).
- rst_n  in  1  asynchronous, active-low reset.
- locked_in  in  1  MMCM LOCKED; asynchronous to Clk.
- clear_cnt  in  1  single-cycle pulse; clears both counters.
- mmcm_rst  out  1  active-high reset to the MMCM RST pin.
- sys_reset_n  out  1  active-low system reset for downstream logic.
- clk_good  out  1  high while clocks are valid.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses while in RUN.
- retry_cnt  out  CNT_W  saturating count of lock timeouts.
- state_dbg  out  2  current FSM state encoding.

## Operation
- **Synchronizer:** `locked_in` passes through a 2-flop synchronizer to give `locked_s`. All decisions use `locked_s`.
- **Timer:** one shared down-counter or up-counter, cleared on every state entry. Its width is $clog2 of max(RST_PULSE, LOCK_TIMEOUT, SETTLE_CYCLES)+1.
- **FSM states and encoding:** RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3.
- **RESET:**
  - `mmcm_rst`=1.
  - When the timer reaches RST_PULSE-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `mmcm_rst`=0.
  - If `locked_s`=1, go to SETTLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1, go to RESET and increment `retry_cnt`.
  - Lock seen on the timeout cycle takes priority over the timeout.
- **SETTLE:**
  - If `locked_s`=0, go to RESET. No counter changes.
  - Otherwise, when the timer reaches SETTLE_CYCLES-1, go to RUN.
- **RUN:**
  - `sys_reset_n`=1 and `clk_good`=1.
  - When loss is detected (see Configuration), go to RESET and increment `lock_loss_cnt`.
- **Counters:**
  - Both counters saturate at 2^CNT_W-1.
  - `clear_cnt` zeroes both counters on the next edge.
  - If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- **Output registers:**
  - `mmcm_rst`, `sys_reset_n` and `clk_good` are registered, decoded from the next state, so they change on the same edge as the state.
  - `sys_reset_n` is deasserted synchronously to Clk. Downstream domains re-synchronize it locally.

## Timing
- **Reset values:**
  - state=RESET, timer=0, `mmcm_rst`=1, `sys_reset_n`=0, `clk_good`=0.
  - Both counters=0, `state_dbg`=0, synchronizer flops=0.
- **Reset assertion:** asynchronous. All outputs take their reset values immediately, including mid-RUN: `sys_reset_n` drops with no clock edge.
- **After rst_n release:** `mmcm_rst` stays high for exactly RST_PULSE rising edges, then falls.
- **Lock acquisition:** `locked_in` rises before edge k.
  - `locked_s`=1 after edge k+1.
  - state=SETTLE after edge k+2.
  - RUN, with `sys_reset_n`=1 and `clk_good`=1, after edge k+2+SETTLE_CYCLES.
- **Timeout:** a WAIT_LOCK attempt with no lock lasts exactly LOCK_TIMEOUT cycles, then RST_PULSE cycles of `mmcm_rst` follow.
- **Loss in RUN (macro undefined):** `locked_in` falls before edge k; `sys_reset_n`=0, `clk_good`=0 and `mmcm_rst`=1 after edge k+2.
- **Metastability:** `locked_in` glitches shorter than one Clk period may be missed. This is acceptable.

## Configuration
- Macro `LOCK_DEBOUNCE_EN`.
- **Defined:** in RUN, loss is declared only after `locked_s`=0 for 4 consecutive cycles.
  - A 4-bit-or-smaller debounce counter resets whenever `locked_s`=1.
  - Loss response is then edge k+5 rather than k+2.
  - SETTLE and WAIT_LOCK are unaffected.
- **Undefined:** a single `locked_s`=0 sample in RUN declares loss.

## Test plan
Parameters for all scenarios: RST_PULSE=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=10.
- **Clean start:** release `rst_n`, raise `locked_in` 20 cycles later.
  - Expect `mmcm_rst` high for exactly 4 cycles after release.
  - Expect `sys_reset_n`/`clk_good` rising exactly 12 edges after `locked_in` rises.
  - Expect `retry_cnt`=0.
- **Timeouts:** hold `locked_in`=0 for 130 cycles, then raise it.
  - Expect 3 `mmcm_rst` pulses of 4 cycles each, spaced 54 cycles apart.
  - Expect `retry_cnt`=2 at lock and RUN reached.
- **Settle glitch:** drop `locked_in` for 3 cycles mid-SETTLE.
  - Expect return to RESET and a new 4-cycle `mmcm_rst` pulse.
  - Expect `lock_loss_cnt`=0.
- **Loss in RUN:** drop `locked_in` for 1 cycle.
  - Macro undefined: `sys_reset_n`=0 two edges later and `lock_loss_cnt`=1.
  - Macro defined: no reaction. A 5-cycle drop yields `lock_loss_cnt`=1.
- **Saturation and clear:** with CNT_W=2, force 5 timeouts and expect `retry_cnt`=3. Then pulse `clear_cnt` on the cycle of a 6th timeout and expect `retry_cnt`=0.
- **Reset mid-RUN:** assert `rst_n`=0 while in RUN.
  - Expect `sys_reset_n`=0, `mmcm_rst`=1 and counters=0 with no clock edge.
  - Expect a full restart after release.
